// File: rtl/npu_wbm_seq.sv
// rtl/npu_wbm_seq.sv - single-beat Wishbone classic master driving the NPU slave
// One command in flight: accept, run one bus cycle (or reject), hold response until consumed.
module npu_wbm_seq #(
    parameter logic [23:0] W_BASE      = 24'h3000_00,
    parameter logic [23:0] S_BASE      = 24'h3000_01,
    parameter logic [23:0] R_BASE      = 24'h3000_02,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_idx,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

    state_t        state_q, state_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [23:0]   base;

    always_comb begin
        case (cmd_op)
            2'b00:   base = W_BASE;
            2'b01:   base = S_BASE;
            default: base = R_BASE;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        timer_d     = timer_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_op == 2'b11) begin
                        state_d     = RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = 32'h0;
                    end else begin
                        state_d = BUS;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        sel_d   = 4'hF;
                        we_d    = (cmd_op != 2'b10);
                        adr_d   = {base, cmd_idx};
                        dat_d   = (cmd_op != 2'b10) ? cmd_data : 32'h0;
                        timer_d = TW'(1);
                    end
                end
            end
            BUS: begin
                // ack is checked before the timeout so a last-cycle ack still succeeds
                if (wbm_ack_i || (timer_q == TW'(TIMEOUT_CYC))) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !wbm_ack_i;
                    rsp_data_d  = (wbm_ack_i && !we_q) ? wbm_dat_i : 32'h0;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = 4'h0;
                    adr_d       = 32'h0;
                    dat_d       = 32'h0;
                    timer_d     = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = 32'h0;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'h0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= 32'h0;
            dat_q       <= 32'h0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            timer_q     <= timer_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_npu_wbm_seq.sv
// tb/tb_npu_wbm_seq.sv - self-checking bench for npu_wbm_seq
// Table vectors, hand sequences for stray ack and async reset, then random commands vs a model.
module tb_npu_wbm_seq;

    localparam int TO = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [7:0]  cmd_idx = 8'h0;
    logic [31:0] cmd_data = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i = 32'h0;
    logic        wbm_ack_i = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    npu_wbm_seq #(.TIMEOUT_CYC(TO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_idx(cmd_idx), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  idx;
        logic [31:0] data;
        logic [31:0] rdata;
        int          lat;
        int          hold;
        logic [31:0] e_adr;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_adr(input logic [1:0] op, input logic [7:0] idx);
        logic [31:0] base;
        base = (op == 2'd0) ? 32'h3000_0000 : (op == 2'd1) ? 32'h3000_0100 : 32'h3000_0200;
        return base + {24'h0, idx};
    endfunction

    // lat: BUS cycle (1-based) in which the slave acks; 0 means the slave never acks
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] idx, input logic [31:0] data,
                           input logic [31:0] rdata, input int lat, input int hold,
                           input logic [31:0] e_adr, input logic e_err, input logic [31:0] e_rdata);
        int waitc, n, cyc_cnt, diff, hd, e_lat, e_cyc;
        bit got;
        e_lat = (op == 2'd3) ? 1 : (lat == 0) ? TO + 1 : lat + 1;
        e_cyc = (op == 2'd3) ? 0 : (lat == 0) ? TO : lat;
        waitc = 0;
        while (!cmd_ready && waitc < 10) begin
            @(negedge wb_clk_i);
            waitc++;
        end
        chk("cmd_ready", {31'h0, cmd_ready}, 32'h1);
        cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx; cmd_data = data;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0; cmd_idx = 8'($urandom); cmd_data = $urandom;
        n = 1; cyc_cnt = 0; diff = 0; got = 1'b0;
        while (n <= 40) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (wbm_cyc_o) begin
                cyc_cnt++;
                if (wbm_adr_o !== e_adr || wbm_we_o !== (op != 2'd2) || wbm_sel_o !== 4'hF ||
                    wbm_stb_o !== 1'b1 || (op != 2'd2 && wbm_dat_o !== data))
                    diff++;
            end
            if (cmd_ready) diff++;
            wbm_ack_i = (lat != 0 && n == lat);
            wbm_dat_i = (n == lat) ? rdata : $urandom;
            @(negedge wb_clk_i);
            n++;
        end
        wbm_ack_i = 1'b0;
        chk("rsp_seen", {31'h0, got}, 32'h1);
        chk("latency", n, e_lat);
        chk("cyc_cycles", cyc_cnt, e_cyc);
        chk("bus_fields", diff, 0);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e_err});
        chk("rsp_data", rsp_data, e_rdata);
        hd = 0;
        repeat (hold) begin
            @(negedge wb_clk_i);
            if (!rsp_valid || rsp_err !== e_err || rsp_data !== e_rdata || cmd_ready || wbm_cyc_o) hd++;
        end
        if (hold > 0) chk("rsp_hold", hd, 0);
        rsp_ready = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;
        chk("rsp_drop", {31'h0, rsp_valid}, 32'h0);
    endtask

    initial begin
        int stray;
        tbl[0] = '{2'd0, 8'h08, 32'h0000_0005, 32'h0,         2,  0,  32'h3000_0008, 1'b0, 32'h0};
        tbl[1] = '{2'd2, 8'h04, 32'h0,         32'h0000_1234, 2,  0,  32'h3000_0204, 1'b0, 32'h1234};
        tbl[2] = '{2'd0, 8'h10, 32'hCAFE_0001, 32'h0,         0,  0,  32'h3000_0010, 1'b1, 32'h0};
        tbl[3] = '{2'd3, 8'h07, 32'h1111_2222, 32'h0,         0,  0,  32'h0,         1'b1, 32'h0};
        tbl[4] = '{2'd1, 8'h22, 32'h1F00_00AA, 32'h0,         1,  10, 32'h3000_0122, 1'b0, 32'h0};
        tbl[5] = '{2'd2, 8'hFF, 32'h0,         32'hDEAD_BEEF, 16, 0,  32'h3000_02FF, 1'b0, 32'hDEAD_BEEF};
        tbl[6] = '{2'd2, 8'h03, 32'h0,         32'h5555_AAAA, 0,  2,  32'h3000_0203, 1'b1, 32'h0};

        #1 wb_rst_ni = 1'b0;
        #11;
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        chk("rst_rsp", {rsp_valid, rsp_err, 30'h0}, 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_wbm", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, 25'h0}, 32'h0);
        chk("rst_adr", wbm_adr_o | wbm_dat_o, 32'h0);
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;

        for (int i = 0; i < 7; i++)
            run_cmd(tbl[i].op, tbl[i].idx, tbl[i].data, tbl[i].rdata, tbl[i].lat, tbl[i].hold,
                    tbl[i].e_adr, tbl[i].e_err, tbl[i].e_rdata);

        for (int i = 0; i < 4; i++)
            run_cmd(2'd1, 8'(i), 32'h0100_0000 + i, 32'h0, 2, 0, 32'h3000_0100 + i, 1'b0, 32'h0);

        stray = 0;
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h7777_7777;
        repeat (3) begin
            @(negedge wb_clk_i);
            if (rsp_valid || wbm_cyc_o || !cmd_ready) stray++;
        end
        wbm_ack_i = 1'b0;
        chk("stray_ack_idle", stray, 0);

        // async reset while the bus cycle is pending
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_idx = 8'h55; cmd_data = 32'hABCD_0000;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        chk("pre_rst_cyc", {31'h0, wbm_cyc_o}, 32'h1);
        #2 wb_rst_ni = 1'b0;
        #1;
        chk("async_rst_cyc_stb", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
        chk("async_rst_rsp", {30'h0, rsp_valid, cmd_ready}, 32'h0);
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        run_cmd(2'd2, 8'h09, 32'h0, 32'h0BAD_F00D, 2, 1, 32'h3000_0209, 1'b0, 32'h0BAD_F00D);

        for (int k = 0; k < 40; k++) begin
            logic [1:0]  op;
            logic [7:0]  idx;
            logic [31:0] data, rdata;
            int          lat, r;
            op    = 2'($urandom);
            idx   = 8'($urandom);
            data  = $urandom;
            rdata = $urandom;
            r     = $urandom_range(0, 7);
            lat   = (r == 0) ? 0 : (r == 1) ? TO : $urandom_range(1, 3);
            run_cmd(op, idx, data, rdata, lat, $urandom_range(0, 3), model_adr(op, idx),
                    (op == 2'd3) || (lat == 0),
                    (op == 2'd2 && lat != 0) ? rdata : 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
